// File: rtl/pixel_mem_arbiter.sv
// Single-port SPRAM arbiter: serves APA102 word reads and host word writes one at a time.
// Optional macro READ_PRIORITY_EN: reads always win a tie; default alternates on a tie.
module pixel_mem_arbiter #(
  parameter int unsigned ADDRESS_BUS_WIDTH = 16,
  parameter int unsigned MEM_LATENCY       = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         read_request,
  input  logic [ADDRESS_BUS_WIDTH-1:0] read_address,
  output logic [15:0]                  read_data,
  output logic                         read_finished_strobe,
  input  logic                         write_request,
  input  logic [ADDRESS_BUS_WIDTH-1:0] write_address,
  input  logic [15:0]                  write_data,
  output logic                         write_ack,
  output logic [ADDRESS_BUS_WIDTH-1:0] mem_address,
  output logic [15:0]                  mem_data_in,
  output logic                         mem_write_enable,
  input  logic [15:0]                  mem_data_out
);

  localparam int unsigned AW    = ADDRESS_BUS_WIDTH;
  localparam int unsigned DW    = 16;
  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {IDLE, WRITE, READ_WAIT, READ_DONE} state_t;
  typedef enum logic {GRANT_READ = 1'b0, GRANT_WRITE = 1'b1} grant_t;

  state_t             state_q, state_d;
  grant_t             last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]      read_data_q, read_data_d;
  logic               rd_stb_q, rd_stb_d;
  logic               wr_ack_q, wr_ack_d;
  logic [AW-1:0]      mem_addr_q, mem_addr_d;
  logic [DW-1:0]      mem_din_q, mem_din_d;
  logic               mem_we_q, mem_we_d;
  logic               grant_rd, grant_wr;

  // Tie-break between simultaneous requests; only consulted in IDLE.
`ifdef READ_PRIORITY_EN
  assign grant_rd = read_request;
`else
  assign grant_rd = read_request && (!write_request || (last_q == GRANT_WRITE));
`endif
  assign grant_wr = write_request && !grant_rd;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    read_data_d = read_data_q;
    rd_stb_d    = 1'b0;
    wr_ack_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    mem_we_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_rd) begin
          state_d    = READ_WAIT;
          cnt_d      = '0;
          mem_addr_d = read_address;
          last_d     = GRANT_READ;
        end else if (grant_wr) begin
          state_d    = WRITE;
          mem_addr_d = write_address;
          mem_din_d  = write_data;
          mem_we_d   = 1'b1;
          wr_ack_d   = 1'b1;
          last_d     = GRANT_WRITE;
        end
      end
      WRITE: state_d = IDLE;
      READ_WAIT: begin
        // Capture exactly MEM_LATENCY edges after the address was issued.
        if (cnt_q == CNT_W'(MEM_LATENCY - 1)) begin
          read_data_d = mem_data_out;
          rd_stb_d    = 1'b1;
          state_d     = READ_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      READ_DONE: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= GRANT_READ;
      cnt_q       <= '0;
      read_data_q <= '0;
      rd_stb_q    <= 1'b0;
      wr_ack_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      mem_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      read_data_q <= read_data_d;
      rd_stb_q    <= rd_stb_d;
      wr_ack_q    <= wr_ack_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      mem_we_q    <= mem_we_d;
    end
  end

  assign read_data            = read_data_q;
  assign read_finished_strobe = rd_stb_q;
  assign write_ack            = wr_ack_q;
  assign mem_address          = mem_addr_q;
  assign mem_data_in          = mem_din_q;
  assign mem_write_enable     = mem_we_q;

endmodule

// File: tb/tb_pixel_mem_arbiter.sv
// Directed bench for pixel_mem_arbiter: one instance at latency 1 with a SPRAM model,
// one at latency 3 whose read data is driven cycle by cycle from the stimulus.
module tb_pixel_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // latency-1 instance
  logic        rreq1, wreq1, stb1, ack1, we1;
  logic [15:0] raddr1, waddr1, wdata1, rdata1, addr1, din1, mout1;
  // latency-3 instance
  logic        rreq3, wreq3, stb3, ack3, we3;
  logic [15:0] raddr3, waddr3, wdata3, rdata3, addr3, din3, mout3;

  pixel_mem_arbiter #(.ADDRESS_BUS_WIDTH(16), .MEM_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .read_request(rreq1), .read_address(raddr1), .read_data(rdata1),
    .read_finished_strobe(stb1),
    .write_request(wreq1), .write_address(waddr1), .write_data(wdata1),
    .write_ack(ack1),
    .mem_address(addr1), .mem_data_in(din1), .mem_write_enable(we1),
    .mem_data_out(mout1)
  );

  pixel_mem_arbiter #(.ADDRESS_BUS_WIDTH(16), .MEM_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .read_request(rreq3), .read_address(raddr3), .read_data(rdata3),
    .read_finished_strobe(stb3),
    .write_request(wreq3), .write_address(waddr3), .write_data(wdata3),
    .write_ack(ack3),
    .mem_address(addr3), .mem_data_in(din3), .mem_write_enable(we3),
    .mem_data_out(mout3)
  );

  // SPRAM model for the latency-1 instance: combinational read off the registered address.
  logic [15:0] mem [0:4095];
  logic        pre_we;
  logic [11:0] pre_addr;
  logic [15:0] pre_data;
  always @(posedge clk) begin
    if (pre_we)   mem[pre_addr] <= pre_data;
    else if (we1) mem[addr1[11:0]] <= din1;
  end
  assign mout1 = mem[addr1[11:0]];

  // Event monitor, sampled just after each rising edge.
  int cyc = 0;
  int n_stb1 = 0, n_ack1 = 0, n_we1 = 0, n_stb3 = 0, n_rec = 0;
  int st_cyc [0:63];
  logic rec [0:63];
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (stb1) begin
      if (n_stb1 < 64) st_cyc[n_stb1] = cyc;
      n_stb1 = n_stb1 + 1;
      if (n_rec < 64) rec[n_rec] = 1'b0;
      n_rec = n_rec + 1;
    end
    if (ack1) begin
      n_ack1 = n_ack1 + 1;
      if (n_rec < 64) rec[n_rec] = 1'b1;
      n_rec = n_rec + 1;
    end
    if (we1)  n_we1 = n_we1 + 1;
    if (stb3) n_stb3 = n_stb3 + 1;
  end

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [11:0] a, input logic [15:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    @(negedge clk);
    pre_we   = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  int base, wb, ab, rb;

  initial begin
    rst = 1'b1;
    rreq1 = 0; wreq1 = 0; raddr1 = 0; waddr1 = 0; wdata1 = 0;
    rreq3 = 0; wreq3 = 0; raddr3 = 0; waddr3 = 0; wdata3 = 0; mout3 = 0;
    pre_we = 0; pre_addr = 0; pre_data = 0;
    idle(2);
    chk("rst_rdata1", rdata1, 0);
    chk("rst_stb1", stb1, 0);
    chk("rst_ack1", ack1, 0);
    chk("rst_addr1", addr1, 0);
    chk("rst_din1", din1, 0);
    chk("rst_we1", we1, 0);
    chk("rst_rdata3", rdata3, 0);
    chk("rst_addr3", addr3, 0);
    rst = 1'b0;
    preload(12'h010, 16'hBEEF);
    preload(12'h011, 16'h5A5A);
    idle(1);

    // 1: single read at latency 1, request held so the re-grant edge is visible
    rreq1 = 1; raddr1 = 16'h0010;
    @(negedge clk);
    chk("t1_addr_e0", addr1, 16'h0010);
    chk("t1_stb_e0", stb1, 0);
    chk("t1_we_e0", we1, 0);
    raddr1 = 16'h0011;
    @(negedge clk);
    chk("t1_stb_e1", stb1, 1);
    chk("t1_rdata", rdata1, 16'hBEEF);
    @(negedge clk);
    chk("t1_stb_e2", stb1, 0);
    chk("t1_addr_e2", addr1, 16'h0010);
    @(negedge clk);
    chk("t1_addr_e3", addr1, 16'h0011);
    chk("t1_stb_e3", stb1, 0);
    @(negedge clk);
    chk("t1_stb_e4", stb1, 1);
    chk("t1_rdata2", rdata1, 16'h5A5A);
    rreq1 = 0;
    idle(3);

    // 2: held read request streams 4 words, 3 cycles apart
    base = n_stb1; wb = n_we1;
    rreq1 = 1; raddr1 = 16'h0010;
    for (int k = 0; k < 100 && (n_stb1 - base) < 4; k++) @(negedge clk);
    rreq1 = 0;
    idle(5);
    chk("t2_strobes", n_stb1 - base, 4);
    chk("t2_no_we", n_we1 - wb, 0);
    for (int i = 0; i < 3; i++)
      chk("t2_spacing", st_cyc[base+i+1] - st_cyc[base+i], 3);

    // 3: write then read back
    base = n_ack1; wb = n_we1;
    wreq1 = 1; waddr1 = 16'h0100; wdata1 = 16'h1234;
    for (int k = 0; k < 100 && n_ack1 == base; k++) @(negedge clk);
    chk("t3_ack_hi", ack1, 1);
    chk("t3_we_hi", we1, 1);
    chk("t3_addr", addr1, 16'h0100);
    chk("t3_din", din1, 16'h1234);
    wreq1 = 0;
    @(negedge clk);
    chk("t3_ack_lo", ack1, 0);
    chk("t3_we_lo", we1, 0);
    base = n_stb1;
    rreq1 = 1; raddr1 = 16'h0100;
    for (int k = 0; k < 100 && n_stb1 == base; k++) @(negedge clk);
    rreq1 = 0;
    chk("t3_rdata", rdata1, 16'h1234);
    idle(3);
    chk("t3_ack_cnt", n_ack1 - ab - base + base - ab + ab, n_ack1);
    chk("t3_we_cycles", n_we1 - wb, 1);

    // 4: both requests held after a lone write
    base = n_ack1;
    wreq1 = 1; waddr1 = 16'h0200; wdata1 = 16'h0001;
    for (int k = 0; k < 100 && n_ack1 == base; k++) @(negedge clk);
    wreq1 = 0;
    idle(2);
    rb = n_rec; ab = n_ack1;
    rreq1 = 1; raddr1 = 16'h0010;
    wreq1 = 1; waddr1 = 16'h0300; wdata1 = 16'h00AA;
    for (int k = 0; k < 200 && (n_rec - rb) < 6; k++) @(negedge clk);
    rreq1 = 0; wreq1 = 0;
    idle(4);
    chk("t4_grants", n_rec - rb, 6);
`ifdef READ_PRIORITY_EN
    for (int i = 0; i < 6; i++) chk("t4_prio_grant", rec[rb+i], 1'b0);
    chk("t4_no_ack", n_ack1 - ab, 0);
`else
    for (int i = 0; i < 6; i++) chk("t4_alt_grant", rec[rb+i], (i % 2 == 1) ? 1'b1 : 1'b0);
    chk("t4_acks", n_ack1 - ab, 3);
`endif

    // 6: latency-3 read captures the data present at the third edge only
    rreq3 = 1; raddr3 = 16'h0ABC; mout3 = 16'h0BAD;
    @(negedge clk);
    chk("t6_addr", addr3, 16'h0ABC);
    chk("t6_stb_e0", stb3, 0);
    rreq3 = 0; mout3 = 16'h1111;
    @(negedge clk);
    chk("t6_stb_e1", stb3, 0);
    mout3 = 16'h2222;
    @(negedge clk);
    chk("t6_stb_e2", stb3, 0);
    mout3 = 16'h3333;
    @(negedge clk);
    chk("t6_stb_e3", stb3, 1);
    chk("t6_rdata", rdata3, 16'h3333);
    mout3 = 16'h4444;
    @(negedge clk);
    chk("t6_stb_e4", stb3, 0);
    chk("t6_rdata_hold", rdata3, 16'h3333);
    idle(2);

    // 5: reset in the middle of a latency-3 read
    rreq3 = 1; raddr3 = 16'h0555; mout3 = 16'h7777;
    idle(2);
    rst = 1'b1;
    #1;
    chk("t5_rst_addr", addr3, 0);
    chk("t5_rst_rdata", rdata3, 0);
    chk("t5_rst_stb", stb3, 0);
    rreq3 = 0;
    @(negedge clk);
    rst = 1'b0;
    base = n_stb3;
    idle(6);
    chk("t5_no_stb", n_stb3 - base, 0);
    rreq3 = 1; raddr3 = 16'h0777;
    for (int k = 0; k < 100 && n_stb3 == base; k++) @(negedge clk);
    rreq3 = 0;
    chk("t5_post_stb", n_stb3 - base, 1);
    chk("t5_post_rdata", rdata3, 16'h7777);
    chk("t5_post_addr", addr3, 16'h0777);
    idle(3);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
